// File: rtl/alarm_seg_writer.sv
// rtl/alarm_seg_writer.sv - Avalon-MM write initiator for the seven-segment PIO data register
// Optional readback/verify path built when SEG_WRITER_READBACK_EN is defined.
module alarm_seg_writer #(
  parameter logic [1:0]  TARGET_ADDR = 2'd0,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [6:0]  cmd_pattern,
  output logic [1:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        done,
  output logic        timeout_err,
  output logic        verify_err,
  input  logic        err_clear,
  output logic [15:0] write_count
);

`ifdef SEG_WRITER_READBACK_EN
  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, RDBK = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1} state_t;
`endif

  // Last wait-count value before the cycle is abandoned on the next stalled edge.
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_nx;
  logic [6:0]  pattern, pattern_nx;
  logic [6:0]  last_written, last_written_nx;
  logic        last_valid, last_valid_nx;
  logic        retry, retry_nx;
  logic [15:0] wait_cnt, wait_cnt_nx;
  logic [15:0] count_nx;
  logic        done_nx;
  logic        terr_set;
  logic        verr_set;

  assign cmd_ready   = (state == IDLE);
  assign avm_address = TARGET_ADDR;

  // Next-state, bookkeeping and completion decisions for the bus cycle.
  always_comb begin
    state_nx        = state;
    pattern_nx      = pattern;
    last_written_nx = last_written;
    last_valid_nx   = last_valid;
    retry_nx        = retry;
    wait_cnt_nx     = wait_cnt;
    count_nx        = write_count;
    done_nx         = 1'b0;
    terr_set        = 1'b0;
    verr_set        = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          pattern_nx = cmd_pattern;
          if (last_valid && (cmd_pattern == last_written)) begin
            done_nx = 1'b1;
          end else begin
            retry_nx    = 1'b0;
            wait_cnt_nx = 16'd0;
            state_nx    = WRITE;
          end
        end
      end
      WRITE: begin
        if (!avm_waitrequest) begin
          last_written_nx = pattern;
          last_valid_nx   = 1'b1;
          count_nx        = write_count + 16'd1;
          wait_cnt_nx     = 16'd0;
`ifdef SEG_WRITER_READBACK_EN
          state_nx        = RDBK;
`else
          state_nx        = IDLE;
          done_nx         = 1'b1;
`endif
        end else if (wait_cnt == WAIT_LAST) begin
          // Abandoned write: forget the display contents so the next command is sent.
          terr_set      = 1'b1;
          last_valid_nx = 1'b0;
          state_nx      = IDLE;
          done_nx       = 1'b1;
        end else begin
          wait_cnt_nx = wait_cnt + 16'd1;
        end
      end
`ifdef SEG_WRITER_READBACK_EN
      RDBK: begin
        if (!avm_waitrequest) begin
          if (avm_readdata[6:0] == pattern) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end else if (!retry) begin
            retry_nx    = 1'b1;
            wait_cnt_nx = 16'd0;
            state_nx    = WRITE;
          end else begin
            verr_set = 1'b1;
            state_nx = IDLE;
            done_nx  = 1'b1;
          end
        end else if (wait_cnt == WAIT_LAST) begin
          terr_set      = 1'b1;
          last_valid_nx = 1'b0;
          state_nx      = IDLE;
          done_nx       = 1'b1;
        end else begin
          wait_cnt_nx = wait_cnt + 16'd1;
        end
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

  // State, bookkeeping and registered bus outputs derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      pattern        <= 7'd0;
      last_written   <= 7'd0;
      last_valid     <= 1'b0;
      retry          <= 1'b0;
      wait_cnt       <= 16'd0;
      write_count    <= 16'd0;
      done           <= 1'b0;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_writedata  <= 32'd0;
    end else begin
      state          <= state_nx;
      pattern        <= pattern_nx;
      last_written   <= last_written_nx;
      last_valid     <= last_valid_nx;
      retry          <= retry_nx;
      wait_cnt       <= wait_cnt_nx;
      write_count    <= count_nx;
      done           <= done_nx;
      avm_chipselect <= (state_nx != IDLE);
      avm_write_n    <= (state_nx != WRITE);
      if (state_nx == WRITE) begin
        avm_writedata <= {25'd0, pattern_nx};
      end
    end
  end

  // Sticky timeout flag; a same-cycle set takes priority over err_clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_err <= 1'b0;
    end else if (terr_set) begin
      timeout_err <= 1'b1;
    end else if (err_clear) begin
      timeout_err <= 1'b0;
    end
  end

`ifdef SEG_WRITER_READBACK_EN
  logic unused_readdata;
  assign unused_readdata = ^avm_readdata[31:7];

  // Sticky verify flag; a same-cycle set takes priority over err_clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      verify_err <= 1'b0;
    end else if (verr_set) begin
      verify_err <= 1'b1;
    end else if (err_clear) begin
      verify_err <= 1'b0;
    end
  end
`else
  logic unused_readdata;
  assign unused_readdata = ^{avm_readdata, verr_set, retry};
  assign verify_err      = 1'b0;
`endif

endmodule

// File: tb/tb_alarm_seg_writer.sv
// tb/tb_alarm_seg_writer.sv - self-checking bench for alarm_seg_writer
// Readback scenarios are included when SEG_WRITER_READBACK_EN is defined.
module tb_alarm_seg_writer;
  localparam logic [1:0] ADDR = 2'd2;
  localparam int         TMO  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [6:0]  cmd_pattern = 7'd0;
  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata = 32'd0;
  logic        avm_waitrequest = 1'b0;
  logic        done;
  logic        timeout_err;
  logic        verify_err;
  logic        err_clear = 1'b0;
  logic [15:0] write_count;

  alarm_seg_writer #(.TARGET_ADDR(ADDR), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_pattern(cmd_pattern), .avm_address(avm_address),
    .avm_chipselect(avm_chipselect), .avm_write_n(avm_write_n),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest), .done(done), .timeout_err(timeout_err),
    .verify_err(verify_err), .err_clear(err_clear), .write_count(write_count)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: what the display holds and what the flags should read.
  logic        m_lv   = 1'b0;
  logic [6:0]  m_last = 7'd0;
  logic [15:0] m_cnt  = 16'd0;
  logic        m_terr = 1'b0;
  logic        m_verr = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_count"}, 32'(write_count), 32'(m_cnt));
    check({tag, "_terr"}, 32'(timeout_err), 32'(m_terr));
    check({tag, "_verr"}, 32'(verify_err), 32'(m_verr));
  endtask

  // One command: waits = stalled edges offered before the first accepted beat,
  // corrupt = number of readbacks answered with 0, clr = err_clear held during it.
  task automatic run_cmd(input logic [6:0] p, input int waits, input int corrupt, input logic clr);
    bit skip, tmo;
    int exp_bus, exp_wr;
    int bus = 0, wr = 0, given = 0, rd_idx = 0, done_cyc = 0;
    bit bad_addr = 0, bad_data = 0;
    skip = m_lv && (p == m_last);
    tmo  = !skip && (waits >= TMO);
    if (clr) begin
      m_terr = 1'b0;
      m_verr = 1'b0;
    end
    if (skip) begin
      exp_bus = 0;
      exp_wr  = 0;
    end else if (tmo) begin
      exp_bus = TMO;
      exp_wr  = 0;
      m_lv    = 1'b0;
      m_terr  = 1'b1;
    end else begin
      exp_bus = waits + 1;
      exp_wr  = 1;
`ifdef SEG_WRITER_READBACK_EN
      exp_bus += 1;
      if (corrupt >= 1) begin
        exp_bus += 2;
        exp_wr = 2;
      end
      if (corrupt >= 2) m_verr = 1'b1;
`endif
      m_lv   = 1'b1;
      m_last = p;
      m_cnt  = m_cnt + 16'(exp_wr);
    end

    check("ready_before_cmd", 32'(cmd_ready), 32'd1);
    cmd_valid       = 1'b1;
    cmd_pattern     = p;
    err_clear       = clr;
    avm_waitrequest = 1'b0;
    for (int c = 1; c <= TMO + 20 && done_cyc == 0; c++) begin
      @(negedge clk);
      cmd_valid   = 1'b0;
      cmd_pattern = 7'($urandom);
      if (done) begin
        done_cyc  = c;
        err_clear = 1'b0;
        check("ready_at_done", 32'(cmd_ready), 32'd1);
      end
      if (avm_chipselect) begin
        bus++;
        if (avm_address !== ADDR) bad_addr = 1;
        avm_waitrequest = (given < waits);
        if (avm_waitrequest) given++;
        if (!avm_write_n) begin
          if (avm_writedata !== {25'd0, p}) bad_data = 1;
          if (!avm_waitrequest) wr++;
        end else if (!avm_waitrequest) begin
          avm_readdata = (rd_idx < corrupt) ? 32'd0 : {25'd0, p};
          rd_idx++;
        end
      end else begin
        avm_waitrequest = 1'b0;
      end
    end
    err_clear = 1'b0;
    check("done_latency", 32'(done_cyc), 32'(exp_bus + 1));
    check("bus_cycles", 32'(bus), 32'(exp_bus));
    check("writes_accepted", 32'(wr), 32'(exp_wr));
    check("bus_address", 32'(bad_addr), 32'd0);
    check("bus_writedata", 32'(bad_data), 32'd0);
    check_flags("after_cmd");
    @(negedge clk);
    check("done_single_pulse", 32'(done), 32'd0);
    check("idle_chipselect", 32'(avm_chipselect), 32'd0);
  endtask

  task automatic pulse_clear();
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    m_terr = 1'b0;
    m_verr = 1'b0;
    check_flags("err_clear");
  endtask

  initial begin
    logic [6:0] p;
    int waits, corrupt, r;
    logic clr;

    repeat (2) @(negedge clk);
    check("rst_chipselect", 32'(avm_chipselect), 32'd0);
    check("rst_write_n", 32'(avm_write_n), 32'd1);
    check("rst_address", 32'(avm_address), 32'(ADDR));
    check("rst_writedata", avm_writedata, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check_flags("rst");
    rst = 1'b0;
    @(negedge clk);

    run_cmd(7'h3F, 0, 0, 1'b0);
    run_cmd(7'h3F, 0, 0, 1'b0);
    run_cmd(7'h06, 0, 0, 1'b0);
    run_cmd(7'h11, 3, 0, 1'b0);
    run_cmd(7'h22, TMO - 1, 0, 1'b0);
    run_cmd(7'h06, 1000, 0, 1'b0);
    run_cmd(7'h06, 0, 0, 1'b0);
    check("writedata_holds", avm_writedata, 32'h06);
    run_cmd(7'h2A, TMO, 0, 1'b0);
    pulse_clear();
    run_cmd(7'h33, 1000, 0, 1'b1);
    pulse_clear();

`ifdef SEG_WRITER_READBACK_EN
    run_cmd(7'h44, 0, 1, 1'b0);
    run_cmd(7'h45, 0, 2, 1'b0);
    pulse_clear();
`endif

    for (int i = 0; i < 40; i++) begin
      p = ($urandom_range(0, 2) == 0) ? m_last : 7'($urandom_range(1, 127));
      r = int'($urandom_range(0, 9));
      if (r < 6)      waits = int'($urandom_range(0, 3));
      else if (r < 8) waits = TMO - 1;
      else            waits = TMO + int'($urandom_range(0, 5));
`ifdef SEG_WRITER_READBACK_EN
      corrupt = (p == 7'd0) ? 0 : int'($urandom_range(0, 2));
`else
      corrupt = 0;
`endif
      clr = ($urandom_range(0, 7) == 0);
      run_cmd(p, waits, corrupt, clr);
    end

    // Asynchronous reset while a write is stalled on waitrequest.
    p = m_last;
    cmd_valid = 1'b1;
    cmd_pattern = 7'h55;
    @(negedge clk);
    cmd_valid = 1'b0;
    avm_waitrequest = 1'b1;
    @(negedge clk);
    check("pre_reset_chipselect", 32'(avm_chipselect), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_chipselect", 32'(avm_chipselect), 32'd0);
    check("async_rst_write_n", 32'(avm_write_n), 32'd1);
    check("async_rst_ready", 32'(cmd_ready), 32'd1);
    check("async_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    avm_waitrequest = 1'b0;
    m_lv = 1'b0;
    m_cnt = 16'd0;
    m_terr = 1'b0;
    m_verr = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("no_done_after_rst", 32'(done), 32'd0);
    end
    check_flags("after_rst");
    run_cmd(7'h55, 0, 0, 1'b0);
    run_cmd(p, 0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
